result_writer: RTL and testbench
================================

# result_writer

Downstream stage of the tanh activation unit. It captures each 16-bit activation result as it is produced and buffers it in a small FIFO. It then writes the result to the output (W) SRAM at consecutive addresses, stalling when the SRAM port is not granted. It reports per-layer completion, saturation statistics and overflow to the controller.

## Interface
Parameters:
- BASE_ADDR, 12'h000, first output SRAM address written after each start
- NUM_RESULTS, 64, results per run (1..4095)
- FIFO_DEPTH, 4, buffer entries (power of 2, ≥2)

Ports:
- clk  in  1  single clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- run  in  1  start pulse; sampled only in IDLE
- result_valid  in  1  one-cycle strobe from tanh stage (its result-available flag)
- result_data  in  16  tanh result, Q-format passed through unchanged
- result_saturated  in  1  tanh input was out of table range; qualified by result_valid
- mem_ready  in  1  SRAM write port granted this cycle
- mem_we  out  1  registered write strobe
- mem_addr  out  12  registered write address
- mem_wdata  out  16  registered write data
- busy  out  1  high in COLLECT and DRAIN
- done  out  1  one-cycle pulse when the last result has been written
- overflow  out  1  sticky; result dropped
- sat_count  out  8  saturated results this run, saturating at 255

## Operation
- States: IDLE, COLLECT, DRAIN, DONE.
- IDLE:
  - run=1 → COLLECT.
  - Clear accept count, write count, sat_count and overflow; write pointer = BASE_ADDR.
  - result_valid is ignored in IDLE; it does not set overflow.
- COLLECT, push:
  - Push on result_valid when the FIFO is not full, or when it is full and a pop happens on the same edge.
  - Otherwise drop the result and set overflow.
  - Each accepted result increments the accept count and, if result_saturated, increments sat_count (held at 255).
  - When the accept count reaches NUM_RESULTS → DRAIN.
- COLLECT and DRAIN, pop:
  - Pop when the FIFO is not empty and mem_ready=1.
  - On a pop edge: mem_we←1, mem_addr←write pointer, mem_wdata←FIFO head; write pointer +1 (mod 4096, wraps 12'hFFF→12'h000); write count +1.
  - Edges without a pop: mem_we←0; mem_addr and mem_wdata hold.
- DRAIN:
  - result_valid is ignored but sets overflow (extra result).
  - When the write count reaches NUM_RESULTS → DONE.
- DONE:
  - done=1 for exactly one cycle, then → IDLE.
  - overflow and sat_count hold until the next run.
- run outside IDLE is ignored.
- reset at any time:
  - State → IDLE; FIFO emptied; no write is issued.
  - All outputs → 0, including mem_addr=12'h000 and sat_count=0.

## Timing
- Minimum latency from result_valid at edge N to mem_we high is one cycle.
  - The push occurs at edge N.
  - The earliest pop is at edge N+1, so mem_we is high from edge N+1 to edge N+2.
- Throughput is one write per cycle while mem_ready=1.
- FIFO_DEPTH consecutive mem_ready=0 cycles with one result per cycle fill the FIFO without loss.
- Empty FIFO with push and no pop on the same edge: no write this edge.
- Full FIFO with push and pop on the same edge: both succeed; occupancy is unchanged.
- done asserts in the cycle after the edge carrying the final mem_we. busy drops on the same edge that done rises.

## Structure
- Package result_writer_pkg: state enum (IDLE, COLLECT, DRAIN, DONE), ADDR_W=12, DATA_W=16, SAT_W=8.
- Sub-module result_fifo:
  - Synchronous FIFO of DATA_W bits with depth FIFO_DEPTH.
  - Ports: push, pop, din, dout, full, empty.
  - Same async active-high reset.
- The top level holds the FSM, counters and registered memory outputs.

## Test plan
- Reset mid-DRAIN with 2 entries buffered → next cycle mem_we=0, busy=0, sat_count=0; no further writes.
- NUM_RESULTS=4, run, results 16'h1000..16'h1003 back-to-back, mem_ready=1 → four writes at addresses 0..3 with matching data, then done pulse; overflow=0.
- mem_ready=0 for 4 cycles while 4 results arrive, then released → no loss; writes in order. A 5th result during the stall → overflow=1 and that result is never written.
- BASE_ADDR=12'hFFE, NUM_RESULTS=4 → addresses FFE, FFF, 000, 001.
- 300 results all with result_saturated=1 → sat_count=255.

Source files
------------

// File: rtl/result_writer_pkg.sv
// Shared types and widths for the tanh result writer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package result_writer_pkg;

    localparam int ADDR_W = 12;
    localparam int DATA_W = 16;
    localparam int SAT_W  = 8;

    localparam logic [SAT_W-1:0] SAT_MAX = '1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DRAIN   = 2'd2,
        DONE    = 2'd3
    } state_t;

    // Increment that sticks at the all-ones ceiling.
    function automatic logic [SAT_W-1:0] sat_inc(input logic [SAT_W-1:0] v);
        return (v == SAT_MAX) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/result_fifo.sv
// Small synchronous FIFO buffering tanh results ahead of the SRAM write port.
// Latency: a pushed word is visible at o_dout the cycle after the push edge.
// Backpressure: push is dropped when full unless a pop happens on the same edge.
module result_fifo
    import result_writer_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = DATA_W
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_din,
    output logic [WIDTH-1:0] o_dout,
    output logic             o_full,
    output logic             o_empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic w_do_pop;
    logic w_do_push;

    assign o_full    = (r_count == CNT_W'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign w_do_pop  = i_pop && !o_empty;
    // A full FIFO still takes a word when the head leaves on the same edge.
    assign w_do_push = i_push && (!o_full || w_do_pop);
    assign o_dout    = r_mem[r_rd_ptr];

    // Storage array; contents need no reset because occupancy gates every read.
    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_din;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally (power-of-2 depth).
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/result_writer.sv
// Captures tanh results, buffers them, and writes them to consecutive W-SRAM addresses.
// Latency: one cycle minimum from result strobe to mem_we; one write per granted cycle.
// Backpressure: stalls writes while mem_ready=0; results arriving with the buffer full are dropped and flag overflow.
module result_writer
    import result_writer_pkg::*;
#(
    parameter logic [ADDR_W-1:0] BASE_ADDR   = 12'h000,
    parameter int                NUM_RESULTS = 64,
    parameter int                FIFO_DEPTH  = 4
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_run,
    input  logic              i_result_valid,
    input  logic [DATA_W-1:0] i_result_data,
    input  logic              i_result_saturated,
    input  logic              i_mem_ready,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_overflow,
    output logic [SAT_W-1:0]  o_sat_count
);

    localparam logic [ADDR_W-1:0] NUM_CNT = ADDR_W'(NUM_RESULTS);

    state_t            r_state;
    logic [ADDR_W-1:0] r_acc_cnt;
    logic [ADDR_W-1:0] r_wr_cnt;
    logic [ADDR_W-1:0] r_wr_ptr;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic              r_busy;
    logic              r_done;
    logic              r_overflow;
    logic [SAT_W-1:0]  r_sat_count;

    logic              w_active;
    logic              w_pop;
    logic              w_push;
    logic              w_full;
    logic              w_empty;
    logic [DATA_W-1:0] w_head;
    logic [ADDR_W-1:0] w_acc_next;
    logic [ADDR_W-1:0] w_wr_next;

    assign w_active   = (r_state == COLLECT) || (r_state == DRAIN);
    assign w_pop      = w_active && !w_empty && i_mem_ready;
    assign w_push     = (r_state == COLLECT) && i_result_valid && (!w_full || w_pop);
    assign w_acc_next = r_acc_cnt + 1'b1;
    assign w_wr_next  = r_wr_cnt + 1'b1;

    result_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_W)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_din   (i_result_data),
        .o_dout  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // Control FSM with counters and registered SRAM/status outputs.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state     <= IDLE;
            r_acc_cnt   <= '0;
            r_wr_cnt    <= '0;
            r_wr_ptr    <= '0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_overflow  <= 1'b0;
            r_sat_count <= '0;
        end else begin
            r_mem_we <= 1'b0;
            r_done   <= 1'b0;

            // Address and data only move on a write; otherwise they hold.
            if (w_pop) begin
                r_mem_we    <= 1'b1;
                r_mem_addr  <= r_wr_ptr;
                r_mem_wdata <= w_head;
                r_wr_ptr    <= r_wr_ptr + 1'b1;
                r_wr_cnt    <= w_wr_next;
            end

            if (w_push) begin
                r_acc_cnt <= w_acc_next;
                if (i_result_saturated) begin
                    r_sat_count <= sat_inc(r_sat_count);
                end
            end

            // A strobe lost to a full buffer, or any strobe after the last
            // expected result, means the producer and this stage disagree.
            if ((r_state == COLLECT && i_result_valid && !w_push) ||
                (r_state == DRAIN && i_result_valid)) begin
                r_overflow <= 1'b1;
            end

            case (r_state)
                IDLE: begin
                    if (i_run) begin
                        r_state     <= COLLECT;
                        r_busy      <= 1'b1;
                        r_acc_cnt   <= '0;
                        r_wr_cnt    <= '0;
                        r_sat_count <= '0;
                        r_overflow  <= 1'b0;
                        r_wr_ptr    <= BASE_ADDR;
                    end
                end
                COLLECT: begin
                    if (w_push && (w_acc_next == NUM_CNT)) begin
                        r_state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (w_pop && (w_wr_next == NUM_CNT)) begin
                        r_state <= DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign o_mem_we    = r_mem_we;
    assign o_mem_addr  = r_mem_addr;
    assign o_mem_wdata = r_mem_wdata;
    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_overflow  = r_overflow;
    assign o_sat_count = r_sat_count;

endmodule

// File: tb/tb_result_writer.sv
// Scoreboard bench for result_writer: queue-based reference model vs DUT.
// Latency: n/a.
// Backpressure: mem_ready driven directed and randomly.
module tb_result_writer;

    localparam logic [11:0] BASE  = 12'hFFE;
    localparam int          N     = 260;
    localparam int          DEPTH = 4;

    localparam int P_IDLE    = 0;
    localparam int P_COLLECT = 1;
    localparam int P_DRAIN   = 2;
    localparam int P_DONE    = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        run;
    logic        rv;
    logic [15:0] rdata;
    logic        rsat;
    logic        mem_ready;

    logic        mem_we;
    logic [11:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        busy;
    logic        done;
    logic        overflow;
    logic [7:0]  sat_count;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [11:0] addr;
        logic [15:0] data;
    } wr_t;

    // Reference model state: a queue stands in for the buffer.
    wr_t         exp_q[$];
    logic [15:0] m_fifo[$];
    int          ph    = P_IDLE;
    int          m_acc = 0;
    int          m_wr  = 0;
    int          m_sat = 0;
    logic        m_ovf = 1'b0;
    logic [11:0] m_ptr = '0;
    bit          m_pop;
    bit          m_can_push;
    wr_t         m_e;

    logic [11:0] last_addr = '0;
    logic [15:0] last_data = '0;
    wr_t         mon_e;

    always #5 clk = ~clk;

    result_writer #(
        .BASE_ADDR   (BASE),
        .NUM_RESULTS (N),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .i_clk              (clk),
        .i_reset            (reset),
        .i_run              (run),
        .i_result_valid     (rv),
        .i_result_data      (rdata),
        .i_result_saturated (rsat),
        .i_mem_ready        (mem_ready),
        .o_mem_we           (mem_we),
        .o_mem_addr         (mem_addr),
        .o_mem_wdata        (mem_wdata),
        .o_busy             (busy),
        .o_done             (done),
        .o_overflow         (overflow),
        .o_sat_count        (sat_count)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: each edge, the head leaves if granted, a new result
    // enters if there is room (counting the departing head), and the run ends
    // once N results were taken and N were written.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_fifo.delete();
            exp_q.delete();
            ph    = P_IDLE;
            m_acc = 0;
            m_wr  = 0;
            m_sat = 0;
            m_ovf = 1'b0;
            m_ptr = '0;
        end else if (ph == P_IDLE) begin
            if (run) begin
                ph    = P_COLLECT;
                m_acc = 0;
                m_wr  = 0;
                m_sat = 0;
                m_ovf = 1'b0;
                m_ptr = BASE;
            end
        end else if (ph == P_DONE) begin
            ph = P_IDLE;
        end else begin
            m_pop      = (m_fifo.size() > 0) && mem_ready;
            m_can_push = (m_fifo.size() < DEPTH) || m_pop;
            if (m_pop) begin
                m_e.addr = m_ptr;
                m_e.data = m_fifo.pop_front();
                exp_q.push_back(m_e);
                m_ptr = m_ptr + 12'd1;
                m_wr++;
            end
            if (ph == P_COLLECT && rv) begin
                if (m_can_push) begin
                    m_fifo.push_back(rdata);
                    m_acc++;
                    if (rsat && m_sat < 255) m_sat++;
                end else begin
                    m_ovf = 1'b1;
                end
            end
            if (ph == P_DRAIN && rv) m_ovf = 1'b1;
            if (ph == P_COLLECT && m_acc == N) ph = P_DRAIN;
            else if (ph == P_DRAIN && m_wr == N) ph = P_DONE;
        end
    end

    // Monitor: compare every DUT write and the status outputs against the model.
    always @(negedge clk) begin
        if (reset) begin
            last_addr = '0;
            last_data = '0;
        end
        if (mem_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: addr=%0h data=%0h, required no write (t=%0t)",
                         mem_addr, mem_wdata, $time);
            end else begin
                mon_e = exp_q.pop_front();
                check("wr_addr", 32'(mem_addr), 32'(mon_e.addr));
                check("wr_data", 32'(mem_wdata), 32'(mon_e.data));
                last_addr = mon_e.addr;
                last_data = mon_e.data;
            end
        end else begin
            check("mem_we", 32'(mem_we), 32'd0);
            check("hold_addr", 32'(mem_addr), 32'(last_addr));
            check("hold_data", 32'(mem_wdata), 32'(last_data));
        end
        check("busy", 32'(busy), 32'((ph == P_COLLECT) || (ph == P_DRAIN)));
        check("done", 32'(done), 32'(ph == P_DONE));
        check("overflow", 32'(overflow), 32'(m_ovf));
        check("sat_count", 32'(sat_count), 32'(m_sat));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit v, input logic [15:0] d, input bit s, input bit r);
        rv        = v;
        rdata     = d;
        rsat      = s;
        mem_ready = r;
        tick();
    endtask

    task automatic start();
        run = 1'b1;
        tick();
        run = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        rv        = 1'b0;
        run       = 1'b0;
        mem_ready = 1'b1;
        while (done !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL %s_done_timeout: done=%b after %0d cycles, required 1", name, done, n);
        end
        tick();
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset     = 1'b1;
        run       = 1'b0;
        rv        = 1'b0;
        rdata     = '0;
        rsat      = 1'b0;
        mem_ready = 1'b0;
        repeat (3) tick();
        check("rst_we", 32'(mem_we), 32'd0);
        check("rst_addr", 32'(mem_addr), 32'd0);
        check("rst_wdata", 32'(mem_wdata), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        check("rst_sat", 32'(sat_count), 32'd0);
        reset = 1'b0;
        repeat (2) tick();

        // Back-to-back results, always granted; every third saturated.
        start();
        for (int i = 0; i < N; i++) drive(1'b1, 16'h1000 + 16'(i), (i % 3) == 0, 1'b1);
        wait_done("a");
        check("a_ovf", 32'(overflow), 32'd0);
        check("a_sat", 32'(sat_count), 32'd87);

        // Strobes in IDLE are ignored and do not flag overflow.
        for (int i = 0; i < 3; i++) drive(1'b1, 16'hBEEF, 1'b1, 1'b1);
        drive(1'b0, 16'h0, 1'b0, 1'b1);
        check("idle_ovf", 32'(overflow), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);

        // Four results into a stalled port fill the buffer; a fifth is dropped.
        start();
        for (int i = 0; i < 4; i++) drive(1'b1, 16'h2000 + 16'(i), 1'b0, 1'b0);
        check("b_no_write", 32'(mem_we), 32'd0);
        drive(1'b1, 16'hDEAD, 1'b1, 1'b0);
        check("b_ovf", 32'(overflow), 32'd1);
        check("b_sat", 32'(sat_count), 32'd0);
        for (int i = 4; i < N; i++) drive(1'b1, 16'h2000 + 16'(i), 1'b0, 1'b1);
        wait_done("b");
        check("b_ovf_hold", 32'(overflow), 32'd1);

        // Random traffic and grants; stray run pulses; extras while draining.
        start();
        n = 0;
        while (ph == P_COLLECT && n < 3000) begin
            run = ($urandom_range(0, 19) == 0);
            drive($urandom_range(0, 9) < 6, 16'($urandom()), 1'($urandom()),
                  $urandom_range(0, 9) < 7);
            n++;
        end
        run = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (ph == P_DRAIN) drive(1'($urandom()), 16'($urandom()), 1'b0, 1'b0);
        end
        wait_done("c");

        // Every result saturated: count pins at 255.
        start();
        for (int i = 0; i < N; i++) drive(1'b1, 16'($urandom()), 1'b1, 1'b1);
        wait_done("d");
        check("d_sat", 32'(sat_count), 32'd255);

        // Reset while draining with two entries buffered.
        start();
        for (int i = 0; i < N - 1; i++) drive(1'b1, 16'h3000 + 16'(i), 1'b0, 1'b1);
        drive(1'b1, 16'h3000 + 16'(N - 1), 1'b1, 1'b0);
        drive(1'b0, 16'h0, 1'b0, 1'b0);
        check("e_busy_drain", 32'(busy), 32'd1);
        check("e_sat_before", 32'(sat_count), 32'd1);
        reset     = 1'b1;
        mem_ready = 1'b1;
        tick();
        check("e_rst_we", 32'(mem_we), 32'd0);
        check("e_rst_busy", 32'(busy), 32'd0);
        check("e_rst_sat", 32'(sat_count), 32'd0);
        check("e_rst_addr", 32'(mem_addr), 32'd0);
        reset = 1'b0;
        repeat (10) drive(1'b0, 16'h0, 1'b0, 1'b1);
        check("e_no_pending", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
